// File: rtl/jtag_tx_pkg.sv
// Shared configuration-chain definitions: default chain geometry, FSM states
// and a width helper used by the transmitter and its serializer.
package jtag_tx_pkg;

  localparam int DEF_NUM_OF_TILES = 4;
  localparam int DEF_MEM_CYCLES   = 4096;
  localparam int DEF_WORD_WIDTH   = 32;
  localparam int TOTAL_BITS       = DEF_NUM_OF_TILES * DEF_MEM_CYCLES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Address/index width that never collapses to zero bits.
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/jtag_tx_serializer.sv
// One-word prefetch buffer feeding a MSB-first shift register. A word arriving
// from memory can bypass the buffer straight into an empty or draining shifter.
module jtag_tx_serializer
  import jtag_tx_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_run,
  input  logic                  i_hold,
  input  logic                  i_capture,
  input  logic [WORD_WIDTH-1:0] i_rdata,
  output logic                  o_buf_empty,
  output logic                  o_data_out,
  output logic                  o_data_valid
);

  localparam int CW = $clog2(WORD_WIDTH + 1);

  logic [WORD_WIDTH-1:0] r_buf;
  logic                  r_buf_valid;
  logic [WORD_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_cnt;

  logic                  w_avail;
  logic [WORD_WIDTH-1:0] w_src;
  logic                  w_valid;
  logic                  w_load;

  // Load decision: shifter empty, or its last bit leaves this cycle.
  always_comb begin
    w_avail = r_buf_valid | i_capture;
    w_src   = r_buf_valid ? r_buf : i_rdata;
    w_valid = (r_cnt != CW'(0)) && !i_hold && i_run;
    w_load  = i_run && !i_hold && w_avail &&
              ((r_cnt == CW'(0)) || (r_cnt == CW'(1)));
  end

  // Prefetch buffer: holds a returned word until the shifter takes it.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_buf       <= '0;
      r_buf_valid <= 1'b0;
    end else if (i_clr) begin
      r_buf       <= '0;
      r_buf_valid <= 1'b0;
    end else if (w_load) begin
      if (r_buf_valid && i_capture) begin
        r_buf <= i_rdata;
      end else begin
        r_buf_valid <= 1'b0;
      end
    end else if (i_capture) begin
      r_buf       <= i_rdata;
      r_buf_valid <= 1'b1;
    end
  end

  // Shift register and remaining-bit count; frozen while held.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_shift <= '0;
      r_cnt   <= CW'(0);
    end else if (i_clr) begin
      r_shift <= '0;
      r_cnt   <= CW'(0);
    end else if (w_load) begin
      r_shift <= w_src;
      r_cnt   <= CW'(WORD_WIDTH);
    end else if (w_valid) begin
      r_shift <= {r_shift[WORD_WIDTH-2:0], 1'b0};
      r_cnt   <= r_cnt - CW'(1);
    end
  end

  assign o_buf_empty  = !r_buf_valid;
  assign o_data_out   = r_shift[WORD_WIDTH-1];
  assign o_data_valid = w_valid;

endmodule

// File: rtl/jtag_tx.sv
// Configuration bitstream transmitter: fetches packed words from config memory
// and streams NUM_OF_TILES*MEM_CYCLES bits MSB-first into the tile chain.
module jtag_tx
  import jtag_tx_pkg::*;
#(
  parameter  int NUM_OF_TILES = DEF_NUM_OF_TILES,
  parameter  int MEM_CYCLES   = DEF_MEM_CYCLES,
  parameter  int WORD_WIDTH   = DEF_WORD_WIDTH,
  localparam int STREAM_BITS  = NUM_OF_TILES * MEM_CYCLES,
  localparam int TOTAL_WORDS  = STREAM_BITS / WORD_WIDTH,
  localparam int ADDR_WIDTH   = clog2_min1(TOTAL_WORDS),
  localparam int TILE_WIDTH   = clog2_min1(NUM_OF_TILES)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_hold,
  output logic                  o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [WORD_WIDTH-1:0] i_mem_rdata,
  output logic                  o_data_out,
  output logic                  o_data_valid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [TILE_WIDTH-1:0] o_tile_idx
);

  localparam int BIT_CW = $clog2(STREAM_BITS + 1);
  localparam int TB_CW  = clog2_min1(MEM_CYCLES);
  localparam int PTR_W  = $clog2(TOTAL_WORDS + 1);

  state_e              r_state;
  state_e              w_next_state;
  logic [BIT_CW-1:0]   r_bit_cnt;
  logic [TB_CW-1:0]    r_tile_bit;
  logic [TILE_WIDTH-1:0] r_tile_idx;
  logic [PTR_W-1:0]    r_word_ptr;
  logic                r_inflight;

  logic w_buf_empty;
  logic w_data_valid;
  logic w_issue;
  logic w_last_bit;

  // Fetch request and end-of-stream detection.
  always_comb begin
    w_issue    = (r_state == RUN) && w_buf_empty && !r_inflight &&
                 (r_word_ptr < PTR_W'(TOTAL_WORDS));
    w_last_bit = w_data_valid && (r_bit_cnt == BIT_CW'(STREAM_BITS - 1));
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next_state = RUN;
        end else begin
          w_next_state = IDLE;
        end
      end
      RUN: begin
        if (w_last_bit) begin
          w_next_state = DONE;
        end else begin
          w_next_state = RUN;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Word pointer, in-flight flag and bit/tile counters; all cleared in IDLE.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_bit_cnt  <= BIT_CW'(0);
      r_tile_bit <= TB_CW'(0);
      r_tile_idx <= TILE_WIDTH'(0);
      r_word_ptr <= PTR_W'(0);
      r_inflight <= 1'b0;
    end else if (r_state == IDLE) begin
      r_bit_cnt  <= BIT_CW'(0);
      r_tile_bit <= TB_CW'(0);
      r_tile_idx <= TILE_WIDTH'(0);
      r_word_ptr <= PTR_W'(0);
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_word_ptr <= r_word_ptr + PTR_W'(1);
      end
      if (w_data_valid) begin
        r_bit_cnt <= r_bit_cnt + BIT_CW'(1);
        if (r_tile_bit == TB_CW'(MEM_CYCLES - 1)) begin
          r_tile_bit <= TB_CW'(0);
          // The final bit leaves tile_idx parked on the last tile.
          if (r_tile_idx != TILE_WIDTH'(NUM_OF_TILES - 1)) begin
            r_tile_idx <= r_tile_idx + TILE_WIDTH'(1);
          end
        end else begin
          r_tile_bit <= r_tile_bit + TB_CW'(1);
        end
      end
    end
  end

  jtag_tx_serializer #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_serializer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clr        (r_state == IDLE),
    .i_run        (r_state == RUN),
    .i_hold       (i_hold),
    .i_capture    (r_inflight),
    .i_rdata      (i_mem_rdata),
    .o_buf_empty  (w_buf_empty),
    .o_data_out   (o_data_out),
    .o_data_valid (w_data_valid)
  );

  assign o_mem_rd_en  = w_issue;
  assign o_mem_addr   = r_word_ptr[ADDR_WIDTH-1:0];
  assign o_data_valid = w_data_valid;
  assign o_busy       = (r_state == RUN);
  assign o_done       = (r_state == DONE);
  assign o_tile_idx   = r_tile_idx;

endmodule
